// File: rtl/neopixel_pkg.sv
// Shared NeoPixel types and default line timing, common to the transmit and receive paths.
package neopixel_pkg;

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    HIGH,
    LOW
  } rx_state_t;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

  localparam int T0H_CYC   = 18;
  localparam int T1H_CYC   = 35;
  localparam int TBIT_CYC  = 62;
  localparam int RESET_CYC = 2500;

  function automatic logic [6:0] sat_inc7(input logic [6:0] v);
    return (v == 7'h7F) ? v : v + 7'd1;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for a single asynchronous level input.
module sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/neopixel_rx_decoder.sv
// Pulse-width decoder for a WS2812 NRZ line: rebuilds 24-bit GRB words, frame latches and framing errors.
// Define NEOPIXEL_RX_ERRCNT_EN to add the saturating err_count output.
module neopixel_rx_decoder #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int MIN_HIGH   = 5,
  parameter int BIT_THRESH = 26,
  parameter int MAX_HIGH   = 50,
  parameter int RESET_CYC  = 2500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        din,
  output logic [23:0] pixel_data,
  output logic        pixel_valid,
  output logic [6:0]  pixel_index,
  output logic        frame_done,
  output logic [6:0]  frame_pixels,
  output logic        frame_err
`ifdef NEOPIXEL_RX_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  import neopixel_pkg::*;

  if (CLK_HZ <= 0 || MIN_HIGH < 1 || BIT_THRESH <= MIN_HIGH || MAX_HIGH <= BIT_THRESH ||
      RESET_CYC <= MAX_HIGH || RESET_CYC > 4095) begin : g_param_chk
    $error("neopixel_rx_decoder: inconsistent timing parameters");
  end

  localparam logic [11:0] C_MIN    = 12'(MIN_HIGH);
  localparam logic [11:0] C_THRESH = 12'(BIT_THRESH);
  localparam logic [11:0] C_MAX    = 12'(MAX_HIGH);
  localparam logic [11:0] C_RESET  = 12'(RESET_CYC);

  logic        w_sdin;
  rx_state_t   r_state;
  rx_state_t   w_state_nx;
  logic [11:0] r_cnt;
  logic [11:0] w_cnt_nx;
  logic [11:0] w_cnt_inc;
  logic [4:0]  r_bit_cnt;
  // Only the first 23 bits are stored; the 24th is merged straight into the output word.
  logic [22:0] r_shreg;
  logic [6:0]  r_pix_cnt;
  logic        w_bit;
  logic        w_shift;
  logic        w_frame_end;
  logic        w_err;

  grb_t        r_pixel;
  logic        r_pixel_valid;
  logic [6:0]  r_pixel_index;
  logic        r_frame_done;
  logic [6:0]  r_frame_pixels;
  logic        r_frame_err;

  sync2 u_sync (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_d     (din),
    .o_q     (w_sdin)
  );

  assign w_cnt_inc = r_cnt + 12'd1;
  assign w_bit     = (r_cnt >= C_THRESH);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= SYNC;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_shift     = 1'b0;
    w_frame_end = 1'b0;
    w_err       = 1'b0;
    unique case (r_state)
      SYNC: begin
        if (w_sdin) begin
          w_cnt_nx = '0;
        end else if (w_cnt_inc == C_RESET) begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end
      IDLE: begin
        w_cnt_nx = '0;
        if (w_sdin) begin
          w_state_nx = HIGH;
          w_cnt_nx   = 12'd1;
        end
      end
      HIGH: begin
        if (w_sdin) begin
          if (w_cnt_inc == C_MAX) begin
            w_err      = 1'b1;
            w_state_nx = SYNC;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = w_cnt_inc;
          end
        end else if (r_cnt < C_MIN) begin
          w_err      = 1'b1;
          w_state_nx = SYNC;
          w_cnt_nx   = '0;
        end else begin
          w_shift    = 1'b1;
          w_state_nx = LOW;
          w_cnt_nx   = 12'd1;
        end
      end
      LOW: begin
        if (w_sdin) begin
          w_state_nx = HIGH;
          w_cnt_nx   = 12'd1;
        end else if (w_cnt_inc == C_RESET) begin
          w_frame_end = 1'b1;
          w_err       = (r_bit_cnt != 5'd0);
          w_state_nx  = IDLE;
          w_cnt_nx    = '0;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end
      default: begin
        w_state_nx = SYNC;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bit_cnt      <= '0;
      r_shreg        <= '0;
      r_pix_cnt      <= '0;
      r_pixel        <= '0;
      r_pixel_valid  <= 1'b0;
      r_pixel_index  <= '0;
      r_frame_done   <= 1'b0;
      r_frame_pixels <= '0;
      r_frame_err    <= 1'b0;
    end else begin
      r_pixel_valid <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_err   <= w_err;
      if (w_shift) begin
        if (r_bit_cnt == 5'd23) begin
          r_pixel       <= grb_t'({r_shreg, w_bit});
          r_pixel_index <= r_pix_cnt;
          r_pixel_valid <= 1'b1;
          r_pix_cnt     <= sat_inc7(r_pix_cnt);
          r_bit_cnt     <= '0;
        end else begin
          r_shreg   <= {r_shreg[21:0], w_bit};
          r_bit_cnt <= r_bit_cnt + 5'd1;
        end
      end
      if (w_frame_end) begin
        r_frame_done   <= 1'b1;
        r_frame_pixels <= r_pix_cnt;
      end
      // Leaving the frame (latch or error) drops any partial pixel and restarts indexing.
      if (w_state_nx == SYNC || w_state_nx == IDLE) begin
        r_bit_cnt <= '0;
        r_pix_cnt <= '0;
      end
    end
  end

  assign pixel_data   = r_pixel;
  assign pixel_valid  = r_pixel_valid;
  assign pixel_index  = r_pixel_index;
  assign frame_done   = r_frame_done;
  assign frame_pixels = r_frame_pixels;
  assign frame_err    = r_frame_err;

`ifdef NEOPIXEL_RX_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_err_cnt <= '0;
    end else if (w_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_neopixel_rx_decoder.sv
// Randomized bench for neopixel_rx_decoder: drives pulse runs on din and compares decoded events to a run-level model.
module tb_neopixel_rx_decoder;

  localparam int MIN_HIGH   = 5;
  localparam int BIT_THRESH = 26;
  localparam int MAX_HIGH   = 50;
  localparam int RESET_CYC  = 2500;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        din   = 1'b0;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [6:0]  pixel_index;
  logic        frame_done;
  logic [6:0]  frame_pixels;
  logic        frame_err;
`ifdef NEOPIXEL_RX_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  neopixel_rx_decoder #(
    .MIN_HIGH   (MIN_HIGH),
    .BIT_THRESH (BIT_THRESH),
    .MAX_HIGH   (MAX_HIGH),
    .RESET_CYC  (RESET_CYC)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .din          (din),
    .pixel_data   (pixel_data),
    .pixel_valid  (pixel_valid),
    .pixel_index  (pixel_index),
    .frame_done   (frame_done),
    .frame_pixels (frame_pixels),
    .frame_err    (frame_err)
`ifdef NEOPIXEL_RX_ERRCNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  always #5 clock = ~clock;

  longint cyc = 0;
  always @(posedge clock) cyc++;

  // kind: 0 = pixel (val = word, idx = index), 1 = frame_done (val = frame_pixels), 2 = frame_err
  typedef struct {
    int     kind;
    longint cyc;
    int     val;
    int     idx;
  } ev_t;

  ev_t exp_q[$];
  ev_t got_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", tag, obs, obs, exp, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (pixel_valid) got_q.push_back('{0, cyc, int'(pixel_data), int'(pixel_index)});
      if (frame_done)  got_q.push_back('{1, cyc, int'(frame_pixels), 0});
      if (frame_err)   got_q.push_back('{2, cyc, 0, 0});
    end
  end

  // Reference model: consumes whole runs of constant din level and predicts events with their cycles.
  bit          m_sync;
  bit          m_inframe;
  bit          m_skip;
  int          m_bits;
  int          m_pix;
  int          m_errs;
  logic [23:0] m_word;

  task automatic model_reset();
    m_sync = 0; m_inframe = 0; m_skip = 0;
    m_bits = 0; m_pix = 0; m_errs = 0; m_word = '0;
  endtask

  task automatic model_step(input logic v, input int n, input longint s);
    int eff;
    if (v) begin
      if (m_sync) begin
        m_inframe = 1;
        if (n >= MAX_HIGH) begin
          exp_q.push_back('{2, s + 3 + MAX_HIGH - 1, 0, 0});
          m_errs++; m_sync = 0;
        end else if (n < MIN_HIGH) begin
          exp_q.push_back('{2, s + n + 3, 0, 0});
          m_errs++; m_sync = 0; m_skip = 1;
        end else begin
          m_word = {m_word[22:0], (n >= BIT_THRESH)};
          m_bits++;
          if (m_bits == 24) begin
            exp_q.push_back('{0, s + n + 3, int'(m_word), m_pix});
            if (m_pix < 127) m_pix++;
            m_bits = 0;
          end
        end
      end
    end else begin
      eff = m_skip ? n - 1 : n;
      m_skip = 0;
      if (!m_sync) begin
        if (eff >= RESET_CYC) begin
          m_sync = 1; m_inframe = 0; m_bits = 0; m_pix = 0;
        end
      end else if (m_inframe && n >= RESET_CYC) begin
        exp_q.push_back('{1, s + 3 + RESET_CYC - 1, m_pix, 0});
        if (m_bits != 0) begin
          exp_q.push_back('{2, s + 3 + RESET_CYC - 1, 0, 0});
          m_errs++;
        end
        m_inframe = 0; m_bits = 0; m_pix = 0;
      end
    end
  endtask

  task automatic drive(input logic v, input int n);
    model_step(v, n, cyc);
    din = v;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_pixel(input logic [23:0] w, input int nbits, input int h0, input int l0,
                            input int h1, input int l1, input int gap);
    logic b;
    for (int i = 0; i < nbits; i++) begin
      b = w[23-i];
      drive(1'b1, b ? h1 : h0);
      drive(1'b0, (i == nbits - 1) ? gap : (b ? l1 : l0));
    end
  endtask

  task automatic send_pixel_rnd(input logic [23:0] w, input int gap);
    logic b;
    for (int i = 0; i < 24; i++) begin
      b = w[23-i];
      drive(1'b1, b ? $urandom_range(MAX_HIGH - 1, BIT_THRESH) : $urandom_range(BIT_THRESH - 1, MIN_HIGH));
      drive(1'b0, (i == 23) ? gap : $urandom_range(20, 1));
    end
  endtask

  task automatic compare_events(input string tag);
    ev_t g;
    ev_t e;
    check_eq({tag, ".count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check_eq({tag, ".kind"}, g.kind, e.kind);
      check_eq({tag, ".cyc"},  g.cyc,  e.cyc);
      check_eq({tag, ".val"},  g.val,  e.val);
      check_eq({tag, ".idx"},  g.idx,  e.idx);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, ".pixel_data"},   pixel_data,   0);
    check_eq({tag, ".pixel_valid"},  pixel_valid,  0);
    check_eq({tag, ".pixel_index"},  pixel_index,  0);
    check_eq({tag, ".frame_done"},   frame_done,   0);
    check_eq({tag, ".frame_pixels"}, frame_pixels, 0);
    check_eq({tag, ".frame_err"},    frame_err,    0);
`ifdef NEOPIXEL_RX_ERRCNT_EN
    check_eq({tag, ".err_count"},    err_count,    0);
`endif
  endtask

  initial begin
    logic [23:0] w;
    int np;

    #2 reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check_outputs_zero("reset");
    model_reset();
    reset = 1'b1;
    drive(1'b0, 2600);

    // Single nominal-timing pixel, then latch.
    send_pixel(24'hFF0000, 24, 18, 44, 35, 27, 2600);
    compare_events("single");

    // 63 pixels alternating two colors, compressed legal timing.
    for (int i = 0; i < 63; i++)
      send_pixel((i % 2) ? 24'h150802 : 24'h200500, 24, 6, 3, 27, 3, (i == 62) ? 2600 : 3);
    compare_events("frame63");

    // Short glitch mid-pixel, resync gap, clean pixel.
    send_pixel(24'hA5A5A5, 10, 6, 3, 27, 3, 20);
    drive(1'b1, 3);
    drive(1'b0, 2600);
    send_pixel(24'h123456, 24, 6, 3, 27, 3, 2600);
    compare_events("glitch");

    // Partial pixel terminated by a latch.
    send_pixel(24'hABC000, 12, 6, 3, 27, 3, 2600);
    compare_events("partial");

    // Stuck-high line; a pixel after a short low is ignored until a full resync gap.
    send_pixel(24'h0F0F0F, 5, 6, 3, 27, 3, 20);
    drive(1'b1, 60);
    drive(1'b0, 100);
    send_pixel(24'h777777, 24, 6, 3, 27, 3, 2600);
    send_pixel(24'h00FF00, 24, 6, 3, 27, 3, 2600);
    compare_events("stuck");

    // Random colors and random legal widths, including the threshold edges.
    for (int f = 0; f < 3; f++) begin
      np = $urandom_range(2, 1);
      for (int p = 0; p < np; p++) begin
        w = 24'($urandom);
        send_pixel_rnd(w, (p == np - 1) ? 2600 : $urandom_range(20, 1));
      end
    end
    compare_events("random");

`ifdef NEOPIXEL_RX_ERRCNT_EN
    check_eq("err_count", err_count, (m_errs > 255) ? 255 : m_errs);
`endif

    // Asynchronous reset in the middle of a high pulse.
    din = 1'b1;
    repeat (10) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    din = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    got_q.delete();
    model_reset();
    reset = 1'b1;
    drive(1'b0, 2600);
    send_pixel(24'h3C5A96, 24, 6, 3, 27, 3, 2600);
    compare_events("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
